// File: rtl/sm_dmem_responder_if.sv
// sm_dmem_responder_if: CPU data-port bundle between a load/store initiator and the data memory.
interface sm_dmem_responder_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        valid;
    logic        ready;
    logic [31:0] rdata;
    modport master(output addr, we, wdata, valid, input ready, rdata);
    modport slave(input addr, we, wdata, valid, output ready, rdata);
endinterface

// File: rtl/sm_dmem_responder.sv
// sm_dmem_responder: word-organised data RAM answering the CPU data port after a programmable wait.
// WAIT_CYCLES=0 gives a combinational-read RAM; otherwise an IDLE/BUSY/RESP FSM stretches each access.
module sm_dmem_responder #(
    parameter int ADDR_WIDTH  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input logic clk,
    input logic rst,
    sm_dmem_responder_if.slave dm
);
    logic [31:0]           r_mem [0:2**ADDR_WIDTH-1];
    logic [ADDR_WIDTH-1:0] w_idx;
    assign w_idx = dm.addr[ADDR_WIDTH+1:2];
    generate
        if (WAIT_CYCLES == 0) begin : g_zero
            always_ff @(posedge clk) begin
                if (dm.valid && dm.we) r_mem[w_idx] <= dm.wdata;
            end
            assign dm.ready = 1'b1;
            assign dm.rdata = r_mem[w_idx];
        end else begin : g_wait
            localparam int CW = $clog2(WAIT_CYCLES + 1);
            typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
            state_t                r_state;
            logic [CW-1:0]         r_cnt;
            logic [ADDR_WIDTH-1:0] r_idx;
            logic                  r_we;
            logic [31:0]           r_wdata;
            logic [31:0]           r_rdata;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_we    <= 1'b0;
                    r_wdata <= '0;
                    r_rdata <= '0;
                end else begin
                    case (r_state)
                        IDLE: if (dm.valid) begin
                            r_idx   <= w_idx;
                            r_we    <= dm.we;
                            r_wdata <= dm.wdata;
                            r_cnt   <= CW'(WAIT_CYCLES - 1);
                            if (WAIT_CYCLES == 1) begin
                                r_state <= RESP;
                                r_rdata <= r_mem[w_idx];
                            end else begin
                                r_state <= BUSY;
                            end
                        end
                        BUSY: if (r_cnt == CW'(1)) begin
                            r_state <= RESP;
                            r_rdata <= r_mem[r_idx];
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
            // Kept apart from the reset block so the array maps onto plain RAM; a reset aborts the write.
            always_ff @(posedge clk) begin
                if (!rst && r_state == RESP && r_we) r_mem[r_idx] <= r_wdata;
            end
            assign dm.ready = (r_state == RESP) || (r_state == IDLE && !dm.valid);
            assign dm.rdata = r_rdata;
        end
    endgenerate
endmodule

// File: tb/tb_sm_dmem_responder.sv
// tb_sm_dmem_responder: directed vectors for the 2-wait responder plus hand sequences for 0/1/3 waits.
module tb_sm_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    always #5 clk = ~clk;

    sm_dmem_responder_if if0 ();
    sm_dmem_responder_if if1 ();
    sm_dmem_responder_if if2 ();
    sm_dmem_responder_if if3 ();
    sm_dmem_responder #(.ADDR_WIDTH(6), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .dm(if0.slave));
    sm_dmem_responder #(.ADDR_WIDTH(6), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .dm(if1.slave));
    sm_dmem_responder #(.ADDR_WIDTH(6), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .dm(if2.slave));
    sm_dmem_responder #(.ADDR_WIDTH(6), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .dm(if3.slave));

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full access on the 2-wait DUT; valid stays high afterwards so the next call is back-to-back.
    task automatic run2(input vec_t v, input string nm);
        tick();
        if2.valid = 1'b1;
        if2.addr  = v.addr;
        if2.we    = v.we;
        if2.wdata = v.wdata;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("%s wait%0d", nm, c), 32'(if2.ready), 32'd0);
            tick();
        end
        @(negedge clk);
        chk({nm, " ready"}, 32'(if2.ready), 32'd1);
        if (v.chk) chk({nm, " rdata"}, if2.rdata, v.exp);
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                                input logic c, input logic [31:0] e);
        vec_t v;
        v.addr = a; v.we = w; v.wdata = d; v.chk = c; v.exp = e;
        return v;
    endfunction

    initial begin
        vecs[0] = mk(32'h10,  1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        vecs[1] = mk(32'h10,  1'b0, 32'h0,        1'b1, 32'hDEADBEEF);
        vecs[2] = mk(32'h04,  1'b1, 32'h11111111, 1'b0, 32'h0);
        vecs[3] = mk(32'h04,  1'b0, 32'h0,        1'b1, 32'h11111111);
        vecs[4] = mk(32'h100, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0);
        vecs[5] = mk(32'h000, 1'b0, 32'h0,        1'b1, 32'hA5A5A5A5);
        vecs[6] = mk(32'h003, 1'b0, 32'h0,        1'b1, 32'hA5A5A5A5);
        vecs[7] = mk(32'h07,  1'b1, 32'h0BADF00D, 1'b1, 32'h11111111);
        vecs[8] = mk(32'h04,  1'b0, 32'h0,        1'b1, 32'h0BADF00D);
        vecs[9] = mk(32'h10,  1'b0, 32'h0,        1'b1, 32'hDEADBEEF);
        {if0.valid, if1.valid, if2.valid, if3.valid} = '0;
        {if0.we, if1.we, if2.we, if3.we} = '0;
        if0.addr = '0; if1.addr = '0; if2.addr = '0; if3.addr = '0;
        if0.wdata = '0; if1.wdata = '0; if2.wdata = '0; if3.wdata = '0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst ready2", 32'(if2.ready), 32'd1);
        chk("rst rdata2", if2.rdata, 32'd0);
        chk("rst ready3", 32'(if3.ready), 32'd1);
        chk("rst rdata3", if3.rdata, 32'd0);
        chk("rst ready1", 32'(if1.ready), 32'd1);

        for (int i = 0; i < 10; i++) run2(vecs[i], $sformatf("v%0d", i));

        // Fields altered after acceptance must be ignored, including we.
        tick();
        if2.addr = 32'h10; if2.we = 1'b0;
        @(negedge clk);
        chk("latch wait0", 32'(if2.ready), 32'd0);
        tick();
        if2.addr = 32'h04; if2.we = 1'b1; if2.wdata = 32'hFFFFFFFF;
        tick();
        @(negedge clk);
        chk("latch ready", 32'(if2.ready), 32'd1);
        chk("latch rdata", if2.rdata, 32'hDEADBEEF);
        run2(mk(32'h04, 1'b0, 32'h0, 1'b1, 32'h0BADF00D), "latch nowrite");

        // Valid dropped mid-transaction: the write still lands.
        tick();
        if2.addr = 32'h20; if2.we = 1'b1; if2.wdata = 32'h55AA55AA;
        @(negedge clk);
        chk("drop wait0", 32'(if2.ready), 32'd0);
        tick();
        if2.valid = 1'b0;
        @(negedge clk);
        chk("drop busy", 32'(if2.ready), 32'd0);
        tick();
        @(negedge clk);
        chk("drop resp", 32'(if2.ready), 32'd1);
        run2(mk(32'h20, 1'b0, 32'h0, 1'b1, 32'h55AA55AA), "drop read");

        // Reset during the RESP cycle of a write discards it.
        run2(mk(32'h30, 1'b1, 32'h00000001, 1'b0, 32'h0), "pre30");
        tick();
        if2.wdata = 32'h00000002;
        tick();
        if2.valid = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rstresp ready", 32'(if2.ready), 32'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstresp idle", 32'(if2.ready), 32'd1);
        run2(mk(32'h30, 1'b0, 32'h0, 1'b1, 32'h00000001), "rstresp read");
        tick();
        if2.valid = 1'b0;

        // WAIT_CYCLES=3: reset one cycle into a write leaves RAM untouched.
        if3.valid = 1'b1; if3.we = 1'b1; if3.addr = 32'h20; if3.wdata = 32'h0000AAAA;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("n3 wait%0d", c), 32'(if3.ready), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("n3 ready", 32'(if3.ready), 32'd1);
        tick();
        if3.wdata = 32'h12345678;
        @(negedge clk);
        chk("n3 abort wait", 32'(if3.ready), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if3.valid = 1'b0;
        @(negedge clk);
        chk("n3 post-rst ready", 32'(if3.ready), 32'd1);
        chk("n3 post-rst rdata", if3.rdata, 32'd0);
        tick();
        if3.valid = 1'b1; if3.we = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("n3 rd wait%0d", c), 32'(if3.ready), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("n3 rd ready", 32'(if3.ready), 32'd1);
        chk("n3 rd rdata", if3.rdata, 32'h0000AAAA);
        tick();
        if3.valid = 1'b0;

        // WAIT_CYCLES=1: IDLE goes straight to RESP.
        if1.valid = 1'b1; if1.we = 1'b1; if1.addr = 32'h0C; if1.wdata = 32'h00000077;
        @(negedge clk);
        chk("n1 wr wait", 32'(if1.ready), 32'd0);
        tick();
        @(negedge clk);
        chk("n1 wr ready", 32'(if1.ready), 32'd1);
        tick();
        if1.we = 1'b0;
        @(negedge clk);
        chk("n1 rd wait", 32'(if1.ready), 32'd0);
        tick();
        @(negedge clk);
        chk("n1 rd ready", 32'(if1.ready), 32'd1);
        chk("n1 rd rdata", if1.rdata, 32'h00000077);
        tick();
        if1.valid = 1'b0;

        // WAIT_CYCLES=0: always ready, combinational read, write at the edge.
        @(negedge clk);
        chk("n0 idle ready", 32'(if0.ready), 32'd1);
        tick();
        if0.valid = 1'b1; if0.we = 1'b1; if0.addr = 32'h08; if0.wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("n0 wr ready", 32'(if0.ready), 32'd1);
        tick();
        if0.we = 1'b0;
        @(negedge clk);
        chk("n0 rd ready", 32'(if0.ready), 32'd1);
        chk("n0 rd rdata", if0.rdata, 32'hCAFEF00D);
        tick();
        if0.we = 1'b1; if0.addr = 32'h10B; if0.wdata = 32'h00000001;
        @(negedge clk);
        chk("n0 old-on-write", if0.rdata, 32'hCAFEF00D);
        tick();
        if0.we = 1'b0; if0.addr = 32'h08;
        @(negedge clk);
        chk("n0 alias rdata", if0.rdata, 32'h00000001);
        tick();
        if0.valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sm_dmem_responder.md
Name: sm_dmem_responder

Overview:
- Data-memory target for the CPU data port (dmAddr/dmWe/dmWData/dmValid/dmReady/dmRData).
- Word-organised RAM with a programmable number of wait states; exercises the CPU stall path (stall while dmReady is low).
- Sits beside the CPU at top level; one outstanding transaction at a time.

Parameters:
- ADDR_WIDTH, 6, word-address bits; RAM depth is 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, cycles dmReady stays low per accepted access; 0 selects zero-wait combinational mode.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- dmAddr  in  32  byte address; word index = dmAddr[ADDR_WIDTH+1:2]; bits [1:0] and above ADDR_WIDTH+1 ignored (aliasing wraps)
- dmWe  in  1  1 = write, 0 = read; qualified by dmValid
- dmWData  in  32  write data
- dmValid  in  1  access request; initiator holds it, with addr/we/wdata, until dmReady
- dmReady  out  1  access done this cycle; also high when no request is pending
- dmRData  out  32  read data, valid while dmReady=1 for a read

Behaviour:
- RAM contents are not cleared by rst and are undefined at power-up.
- Mode WAIT_CYCLES=0: no FSM. dmReady=1 constantly. dmRData = mem[idx] combinationally. Write occurs at the clock edge when dmValid&dmWe. A read of the word being written returns the old value in that cycle.
- Mode WAIT_CYCLES=N>0 uses FSM states IDLE, BUSY, RESP, a counter, and latched addr/we/wdata.
- IDLE, dmValid=0: dmReady=1; stay in IDLE.
- IDLE, dmValid=1: dmReady=0 (combinational); latch idx/we/wdata; cnt<=N-1.
  - N=1: go to RESP.
  - Otherwise: go to BUSY.
- BUSY: dmReady=0.
  - cnt==1: go to RESP and load dmRData<=mem[latched idx].
  - Otherwise: cnt<=cnt-1.
- Transition IDLE->RESP (N=1): dmRData<=mem[latched idx] at the same edge.
- RESP: dmReady=1; dmRData holds. If latched we, write mem[latched idx]<=latched wdata at the end of the RESP cycle. Next state is always IDLE.
- Latency: request first seen in cycle T gives dmReady low for T..T+N-1, high at T+N. Earliest next acceptance is T+N+1. Back-to-back requests with dmValid held continuously are legal and each costs N+1 cycles.
- Request fields changing after acceptance are ignored; latched values are used.
- dmValid dropping mid-transaction: the transaction still completes, including the write.
- For writes, dmRData in RESP shows the pre-write word; the initiator ignores it.
- Reset values (N>0): state IDLE, cnt 0, latches 0, dmRData 0, so dmReady=1 after reset when dmValid=0.
- rst mid-transaction: return to IDLE next edge; a pending write is discarded, and no RAM write happens on a reset cycle.
- dmReady is combinational from state and dmValid only; there is no path from dmAddr to dmReady.
- Counter width is clog2(WAIT_CYCLES+1) bits minimum; WAIT_CYCLES up to 255 supported.

Test Plan:
- WAIT_CYCLES=2, reset, dmValid=0 -> dmReady=1 and dmRData=0 from the first post-reset cycle.
- WAIT_CYCLES=2, write 0xDEADBEEF at addr 0x10 (valid held) -> dmReady low in cycles T and T+1, high at T+2. Then read 0x10 -> dmReady high at T'+2 with dmRData=0xDEADBEEF.
- WAIT_CYCLES=2, write 0x11111111 to 0x04, then immediately read 0x04 with valid held continuously -> read completes 3 cycles after the write completes and returns 0x11111111.
- WAIT_CYCLES=2, ADDR_WIDTH=6, write 0xA5A5A5A5 at 0x100, read at 0x000 and at 0x003 -> both return 0xA5A5A5A5 (wrap and low-bit ignore).
- WAIT_CYCLES=3, start write 0x12345678 to 0x20 and assert rst in cycle T+1; then read 0x20 -> old contents unchanged, dmReady=1 immediately after reset.
- WAIT_CYCLES=0, write 0xCAFEF00D to 0x08 then read 0x08 -> dmReady=1 every cycle; read returns 0xCAFEF00D in the cycle after the write.
